// File: rtl/axi_burst_writer.sv
// -----------------------------------------------------------------------------
// axi_burst_writer
// Turns a (byte address, byte length) write request plus a stream of
// bus-aligned data beats into AXI4 INCR write bursts, then reports one
// OK/ERROR status per request once every burst has been acknowledged.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   req_addr/req_length      request start byte address and byte count
//   req_vld/req_rdy          request handshake
//   data_in_data/vld/rdy     write data beats, one bus-aligned word each
//   resp_data/vld/rdy        request status (0 = OK, 1 = ERROR)
//   axi_aw_*                 AXI write address channel (master side)
//   axi_w_*                  AXI write data channel (master side)
//   axi_b_*                  AXI write response channel (master side)
//
// Configuration
//   AXI_BURST_WRITER_BOUNDARY_SPLIT_EN  when defined, bursts are also cut at
//                                       every 4 KiB address boundary; when
//                                       undefined, bursts are cut only at
//                                       MAX_BURST beats.
// -----------------------------------------------------------------------------
module axi_burst_writer #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned AXI_ID    = 0,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_length,
    input  logic                req_vld,
    output logic                req_rdy,

    input  logic [DATA_W-1:0]   data_in_data,
    input  logic                data_in_vld,
    output logic                data_in_rdy,

    output logic                resp_data,
    output logic                resp_vld,
    input  logic                resp_rdy,

    output logic [ID_W-1:0]     axi_aw_awid,
    output logic [ADDR_W-1:0]   axi_aw_awaddr,
    output logic [2:0]          axi_aw_awsize,
    output logic [7:0]          axi_aw_awlen,
    output logic [1:0]          axi_aw_awburst,
    output logic                axi_aw_awvalid,
    input  logic                axi_aw_awready,

    output logic [DATA_W-1:0]   axi_w_wdata,
    output logic [DATA_W/8-1:0] axi_w_wstrb,
    output logic                axi_w_wlast,
    output logic                axi_w_wvalid,
    input  logic                axi_w_wready,

    input  logic [2:0]          axi_b_bresp,
    input  logic [ID_W-1:0]     axi_b_bid,
    input  logic                axi_b_bvalid,
    output logic                axi_b_bready
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned SIZE   = $clog2(BYTES);
    localparam int unsigned BEAT_W = LEN_W + 1;
    localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, AW, W, WAIT_B, RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;       // address of the next burst
    logic [BEAT_W-1:0]   req_left;     // request beats not yet taken from data_in
    logic [CNT_W-1:0]    burst_cnt;    // beats in the burst being issued
    logic [CNT_W-1:0]    in_left;      // beats of this burst still to take from data_in
    logic [BYTES-1:0]    last_strb;    // strobe for the request's final beat
    logic [DATA_W-1:0]   skid_data;
    logic [BYTES-1:0]    skid_strb;
    logic                skid_last;
    logic                skid_vld;
    logic [BEAT_W-1:0]   outstanding;  // bursts whose B response is still due
    logic                err;          // sticky: some B response was not OKAY

    // BID carries no information for a single-ID master.
    logic unused_bid;
    assign unused_bid = ^axi_b_bid;

    assign axi_aw_awid    = ID_W'(AXI_ID);
    assign axi_aw_awsize  = 3'(SIZE);
    assign axi_aw_awburst = 2'b01;

    // Handshakes, all formed from registered valid/ready outputs.
    logic req_hs, aw_hs, in_hs, w_hs, b_hs, resp_hs;
    assign req_hs  = req_vld        & req_rdy;
    assign aw_hs   = axi_aw_awvalid & axi_aw_awready;
    assign in_hs   = data_in_vld    & data_in_rdy;
    assign w_hs    = axi_w_wvalid   & axi_w_wready;
    assign b_hs    = axi_b_bvalid   & axi_b_bready;
    assign resp_hs = resp_vld       & resp_rdy;

    // Request decode: beat count and final-beat strobe.
    logic [BEAT_W-1:0] req_beats_c;
    logic [LEN_W-1:0]  rem_c;
    logic [BYTES-1:0]  req_strb_c;
    assign req_beats_c = (BEAT_W'(req_length) + BEAT_W'(BYTES - 1)) >> SIZE;
    assign rem_c       = req_length & LEN_W'(BYTES - 1);

    always_comb begin
        req_strb_c = '1;
        if (rem_c != '0) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                req_strb_c[i] = (LEN_W'(i) < rem_c);
            end
        end
    end

    // Beats in the next burst: limited by what is left and by MAX_BURST.
    logic [CNT_W-1:0] burst_c;
`ifdef AXI_BURST_WRITER_BOUNDARY_SPLIT_EN
    logic [11:0] page_off_c;
    logic [12:0] page_beats_c;
    assign page_off_c   = 12'(addr_q);
    assign page_beats_c = (13'h1000 - {1'b0, page_off_c}) >> SIZE;
`endif

    always_comb begin
        burst_c = CNT_W'(MAX_BURST);
        if (req_left < BEAT_W'(MAX_BURST)) begin
            burst_c = CNT_W'(req_left);
        end
`ifdef AXI_BURST_WRITER_BOUNDARY_SPLIT_EN
        if (page_beats_c < 13'(burst_c)) begin
            burst_c = CNT_W'(page_beats_c);
        end
`endif
    end

    // Accepted beat attributes and skid occupancy for the next cycle.
    logic             in_last_c, in_final_c, load_out_c, skid_vld_nxt;
    logic [BYTES-1:0] in_strb_c;
    logic [CNT_W-1:0] in_left_nxt;
    assign in_last_c   = (in_left == CNT_W'(1));
    assign in_final_c  = (req_left == BEAT_W'(1));
    assign in_strb_c   = in_final_c ? last_strb : '1;
    assign load_out_c  = in_hs & (~axi_w_wvalid | w_hs);
    assign in_left_nxt = in_left - CNT_W'(in_hs);

    always_comb begin
        skid_vld_nxt = skid_vld;
        if (in_hs && axi_w_wvalid && !w_hs) begin
            skid_vld_nxt = 1'b1;
        end else if (!in_hs && w_hs) begin
            skid_vld_nxt = 1'b0;
        end
    end

    // Outstanding-B count: AW adds one, B removes one, both together cancel.
    logic [BEAT_W-1:0] outstanding_nxt;
    always_comb begin
        outstanding_nxt = outstanding;
        if (aw_hs && !b_hs) begin
            outstanding_nxt = outstanding + BEAT_W'(1);
        end else if (!aw_hs && b_hs) begin
            outstanding_nxt = outstanding - BEAT_W'(1);
        end
    end

    // Control FSM, W skid stage and B bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            req_rdy        <= 1'b0;
            data_in_rdy    <= 1'b0;
            resp_vld       <= 1'b0;
            resp_data      <= 1'b0;
            axi_aw_awaddr  <= '0;
            axi_aw_awlen   <= '0;
            axi_aw_awvalid <= 1'b0;
            axi_w_wdata    <= '0;
            axi_w_wstrb    <= '0;
            axi_w_wlast    <= 1'b0;
            axi_w_wvalid   <= 1'b0;
            axi_b_bready   <= 1'b0;
            addr_q         <= '0;
            req_left       <= '0;
            burst_cnt      <= '0;
            in_left        <= '0;
            last_strb      <= '0;
            skid_data      <= '0;
            skid_strb      <= '0;
            skid_last      <= 1'b0;
            skid_vld       <= 1'b0;
            outstanding    <= '0;
            err            <= 1'b0;
        end else begin
            outstanding  <= outstanding_nxt;
            axi_b_bready <= (outstanding_nxt != '0);
            if (b_hs && (axi_b_bresp != 3'd0)) begin
                err <= 1'b1;
            end

            // One-entry skid: a beat goes straight to W when the W register
            // is free or draining, otherwise it parks until W drains.
            if (in_hs) begin
                in_left  <= in_left_nxt;
                req_left <= req_left - BEAT_W'(1);
                if (load_out_c) begin
                    axi_w_wdata  <= data_in_data;
                    axi_w_wstrb  <= in_strb_c;
                    axi_w_wlast  <= in_last_c;
                    axi_w_wvalid <= 1'b1;
                end else begin
                    skid_data <= data_in_data;
                    skid_strb <= in_strb_c;
                    skid_last <= in_last_c;
                end
            end else if (w_hs) begin
                if (skid_vld) begin
                    axi_w_wdata <= skid_data;
                    axi_w_wstrb <= skid_strb;
                    axi_w_wlast <= skid_last;
                end else begin
                    axi_w_wvalid <= 1'b0;
                end
            end
            skid_vld <= skid_vld_nxt;

            case (state)
                IDLE: begin
                    if (req_hs) begin
                        req_rdy   <= 1'b0;
                        addr_q    <= req_addr & ~ADDR_W'(BYTES - 1);
                        req_left  <= req_beats_c;
                        last_strb <= req_strb_c;
                        if (req_length == '0) begin
                            resp_vld  <= 1'b1;
                            resp_data <= 1'b0;
                            state     <= RESP;
                        end else begin
                            state <= AW;
                        end
                    end else begin
                        req_rdy <= 1'b1;
                    end
                end

                // First cycle in AW computes and presents the burst.
                AW: begin
                    if (!axi_aw_awvalid) begin
                        axi_aw_awvalid <= 1'b1;
                        axi_aw_awaddr  <= addr_q;
                        axi_aw_awlen   <= 8'(burst_c - CNT_W'(1));
                        burst_cnt      <= burst_c;
                        in_left        <= burst_c;
                    end else if (axi_aw_awready) begin
                        axi_aw_awvalid <= 1'b0;
                        data_in_rdy    <= 1'b1;
                        addr_q         <= addr_q + (ADDR_W'(burst_cnt) << SIZE);
                        state          <= W;
                    end
                end

                W: begin
                    data_in_rdy <= (in_left_nxt != '0) && !skid_vld_nxt;
                    if (w_hs && axi_w_wlast) begin
                        data_in_rdy <= 1'b0;
                        state       <= (req_left != '0) ? AW : WAIT_B;
                    end
                end

                WAIT_B: begin
                    if (outstanding == '0) begin
                        resp_vld  <= 1'b1;
                        resp_data <= err;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (resp_hs) begin
                        resp_vld  <= 1'b0;
                        resp_data <= 1'b0;
                        err       <= 1'b0;
                        req_rdy   <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_burst_writer.md
AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning AXI data width in bits (power of two, 8..512).
REQ-003 The block SHALL have parameter LEN_W, default 16, meaning request byte-length width.
REQ-004 The block SHALL have parameter ID_W, default 4, meaning AXI ID width.
REQ-005 The block SHALL have parameter AXI_ID, default 0, meaning the constant awid value.
REQ-006 The block SHALL have parameter MAX_BURST, default 16, meaning maximum beats per burst (1..256).
REQ-007 The block SHALL use one clock; reset is synchronous and active-low.
REQ-008 Clock and reset ports SHALL be: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-009 Request ports SHALL be: req_addr  in  ADDR_W  start byte address; req_length  in  LEN_W  byte count; req_vld  in  1; req_rdy  out  1.
REQ-010 Data ports SHALL be: data_in_data  in  DATA_W  one bus-aligned beat; data_in_vld  in  1; data_in_rdy  out  1.
REQ-011 Response ports SHALL be: resp_data  out  1  0=OK, 1=ERROR; resp_vld  out  1; resp_rdy  in  1.
REQ-012 AW ports SHALL be: axi_aw_awid  out  ID_W; axi_aw_awaddr  out  ADDR_W; axi_aw_awsize  out  3; axi_aw_awlen  out  8; axi_aw_awburst  out  2; axi_aw_awvalid  out  1; axi_aw_awready  in  1.
REQ-013 W ports SHALL be: axi_w_wdata  out  DATA_W; axi_w_wstrb  out  DATA_W/8; axi_w_wlast  out  1; axi_w_wvalid  out  1; axi_w_wready  in  1.
REQ-014 B ports SHALL be: axi_b_bresp  in  3; axi_b_bid  in  ID_W; axi_b_bvalid  in  1; axi_b_bready  out  1.

Function
REQ-015 The FSM SHALL have states IDLE, AW, W, WAIT_B, RESP; all outputs SHALL be registered.
REQ-016 IDLE SHALL assert req_rdy; on req handshake it latches the address with its low log2(DATA_W/8) bits forced to zero, sets beats = ceil(length/BYTES), and moves to AW (to RESP with resp_data=0 if length==0, issuing no AXI traffic).
REQ-017 Burst beat count SHALL be min(remaining beats, MAX_BURST, beats to the next 4 KiB boundary when splitting is enabled); awlen = count-1, awsize = log2(DATA_W/8), awburst = 2'b01 (INCR), awid = AXI_ID.
REQ-018 AW SHALL hold awvalid until awready, then move to W; it SHALL increment the outstanding-B counter by one.
REQ-019 W SHALL pass data_in_data to wdata with data_in_rdy = wready when wvalid is low or accepted (one-entry skid; no bubble at full throughput); wlast SHALL be set on the final beat of each burst.
REQ-020 wstrb SHALL be all-ones, except on the request's final beat, where only the low (length mod BYTES) bits are set (all-ones if the remainder is 0).
REQ-021 After the last beat of a burst, the FSM SHALL go to AW if beats remain, otherwise to WAIT_B.
REQ-022 axi_b_bready SHALL be 1 whenever the outstanding counter is nonzero; each B handshake SHALL decrement it; a simultaneous AW and B handshake SHALL leave it unchanged.
REQ-023 Any bresp != 0 SHALL set a sticky error flag; bid SHALL be ignored.
REQ-024 WAIT_B SHALL go to RESP when the counter is 0; RESP SHALL hold resp_vld with resp_data = error flag until resp_rdy, then return to IDLE and clear the flag.
REQ-025 data_in_rdy SHALL be 0 outside W; excess input beats beyond the computed count SHALL NOT be consumed.

Reset
REQ-026 When rst=0 at a clk edge, the state SHALL be IDLE, and all valid/ready outputs, counters, wlast, and the error flag SHALL be 0.
REQ-027 Reset asserted mid-request SHALL abandon the request with no response; outstanding B responses SHALL be forgotten.

Configuration
REQ-028 With macro AXI_BURST_WRITER_BOUNDARY_SPLIT_EN defined, bursts SHALL NOT cross a 4 KiB boundary; without it, bursts SHALL split only at MAX_BURST.

Verification (DATA_W=32, MAX_BURST=4)
REQ-029 Request addr 0x0100, len 8 -> one AW (0x0100, awlen 1), two beats with wstrb 0xF and 0xF, wlast on beat 2, bresp 0 -> resp_data 0.
REQ-030 Request addr 0x0100, len 6 -> two beats with wstrb 0xF then 0x3; addr 0x0103 -> awaddr 0x0100.
REQ-031 Request len 40 at 0x0200 -> AWs (0x0200, len 3), (0x0210, len 3), (0x0220, len 1); resp after 3 B.
REQ-032 Request addr 0x0FF8, len 16 -> with macro: AW (0x0FF8, len 1) then (0x1000, len 1); without macro: single AW (0x0FF8, len 3).
REQ-033 Three-burst request with bresp=2 on burst 2 -> resp_data 1; a following clean request -> resp_data 0; len 0 -> immediate resp 0 with no AW.
REQ-034 rst=0 during the W phase -> all outputs 0 on the next cycle; a new request then completes normally.
